// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
// Shared definitions for the DES permutation unit:
//   - des_mode_e   : permutation select carried alongside each word
//   - width consts : output widths of the P and E permutations, block width
//   - P/E/IP/FP    : FIPS 46-3 tables, 1-based as printed in the standard
//   - des_permute  : stateless table application, out[i] = in[T[i]-1]
// Port bit i corresponds to FIPS bit i+1; unused upper output bits are 0.
// -----------------------------------------------------------------------------
package des_pkg;

    typedef enum logic [1:0] {
        MODE_P  = 2'd0,   // 32 -> 32 round permutation
        MODE_E  = 2'd1,   // 32 -> 48 expansion
        MODE_IP = 2'd2,   // 64 -> 64 initial permutation
        MODE_FP = 2'd3    // 64 -> 64 final permutation (IP inverse)
    } des_mode_e;

    localparam int DES_W = 64;
    localparam int P_W   = 32;
    localparam int E_W   = 48;

    localparam int unsigned P_TAB [P_W] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    localparam int unsigned E_TAB [E_W] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1
    };

    localparam int unsigned IP_TAB [DES_W] = '{
        58, 50, 42, 34, 26, 18, 10,  2,
        60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6,
        64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1,
        59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5,
        63, 55, 47, 39, 31, 23, 15,  7
    };

    localparam int unsigned FP_TAB [DES_W] = '{
        40,  8, 48, 16, 56, 24, 64, 32,
        39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30,
        37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28,
        35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26,
        33,  1, 41,  9, 49, 17, 57, 25
    };

    // Pure wiring: each output bit selects one input bit. Input bits beyond
    // the mode's input width are never referenced by any table, so they are
    // ignored automatically.
    function automatic logic [DES_W-1:0] des_permute(input des_mode_e        mode,
                                                     input logic [DES_W-1:0] din);
        logic [DES_W-1:0] perm;
        logic [31:0]      src;
        // NOTE: every variable gets a value before any branch so the
        // combinational result never depends on a previous evaluation.
        perm = '0;
        src  = '0;
        case (mode)
            MODE_P: begin
                for (int i = 0; i < P_W; i++) begin
                    src          = P_TAB[i[4:0]] - 32'd1;
                    perm[i[5:0]] = din[src[5:0]];
                end
            end
            MODE_E: begin
                for (int i = 0; i < E_W; i++) begin
                    src          = E_TAB[i[5:0]] - 32'd1;
                    perm[i[5:0]] = din[src[5:0]];
                end
            end
            MODE_IP: begin
                for (int i = 0; i < DES_W; i++) begin
                    src          = IP_TAB[i[5:0]] - 32'd1;
                    perm[i[5:0]] = din[src[5:0]];
                end
            end
            MODE_FP: begin
                for (int i = 0; i < DES_W; i++) begin
                    src          = FP_TAB[i[5:0]] - 32'd1;
                    perm[i[5:0]] = din[src[5:0]];
                end
            end
            default: perm = '0;
        endcase
        return perm;
    endfunction

endpackage

// File: rtl/des_perm_stage.sv
// -----------------------------------------------------------------------------
// des_perm_stage
// One valid/ready register slice holding {valid, mode, data}.
//   clk, rst      : clock, synchronous active-high reset
//   i_valid       : upstream word present
//   i_mode/i_data : upstream mode and (already permuted) data
//   i_dn_ready    : downstream can take this stage's word this cycle
//   o_valid       : this stage holds a word
//   o_mode/o_data : registered mode and data
// The stage loads whenever it is empty or its word leaves this cycle.
// -----------------------------------------------------------------------------
module des_perm_stage
    import des_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    input  des_mode_e    i_mode,
    input  logic [W-1:0] i_data,
    input  logic         i_dn_ready,
    output logic         o_valid,
    output des_mode_e    o_mode,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    des_mode_e    r_mode;
    logic [W-1:0] r_data;
    logic         w_load;

    assign w_load = !r_valid || i_dn_ready;

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every stage samples its neighbour's pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: mode/data are reset too, because the last stage drives the
            // output ports directly and they must read 0 after reset.
            r_valid <= 1'b0;
            r_mode  <= MODE_P;
            r_data  <= '0;
        end else if (w_load) begin
            r_valid <= i_valid;
            // Payload only changes on a real load; a stalled word stays put.
            if (i_valid) begin
                r_mode <= i_mode;
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_mode  = r_mode;
    assign o_data  = r_data;

endmodule

// File: rtl/des_perm_unit.sv
// -----------------------------------------------------------------------------
// des_perm_unit
// Applies one of the DES bit permutations (P, E, IP, FP) combinationally on
// the input word and carries the result through STAGES valid/ready register
// slices. Full throughput of one word per cycle; lossless backpressure.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake (never ready during reset)
//   in_mode, data_in    : permutation select and input word
//   out_valid/out_ready : output handshake, driven from the last stage
//   out_mode, data_out  : mode and permuted word of the oldest entry
//   busy                : any stage holds a word
// -----------------------------------------------------------------------------
module des_perm_unit
    import des_pkg::*;
#(
    parameter int STAGES = 2,
    parameter int W      = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_mode,
    input  logic [W-1:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [1:0]   out_mode,
    output logic [W-1:0] data_out,
    output logic         busy
);

    // Index 0 is the permuted input; index s+1 is the output of stage s.
    logic [STAGES:0] w_vld;
    des_mode_e       w_mode [STAGES+1];
    logic [W-1:0]    w_data [STAGES+1];
    // w_accept[s]: stage s can load this cycle; w_accept[STAGES] is the consumer.
    logic [STAGES:0] w_accept;

    assign w_vld[0]  = in_valid && !rst;
    assign w_mode[0] = des_mode_e'(in_mode);
    assign w_data[0] = des_permute(w_mode[0], data_in);

    assign w_accept[STAGES] = out_ready;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        // A stage can load if the consumer drains or any stage from here to
        // the output has a hole. Written in closed form from the valid bits so
        // the ready path is a flat function of registers, not a chain.
        assign w_accept[s] = out_ready || !(&w_vld[STAGES:s+1]);

        des_perm_stage #(
            .W (W)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .i_valid    (w_vld[s]),
            .i_mode     (w_mode[s]),
            .i_data     (w_data[s]),
            .i_dn_ready (w_accept[s+1]),
            .o_valid    (w_vld[s+1]),
            .o_mode     (w_mode[s+1]),
            .o_data     (w_data[s+1])
        );
    end

    assign in_ready  = w_accept[0] && !rst;
    assign out_valid = w_vld[STAGES];
    assign out_mode  = w_mode[STAGES];
    assign data_out  = w_data[STAGES];
    assign busy      = |w_vld[STAGES:1];

endmodule

// File: tb/tb_des_perm_unit.sv
// -----------------------------------------------------------------------------
// tb_des_perm_unit
// Scoreboard bench for des_perm_unit (STAGES=2). The driver pushes the
// expected result when a word is accepted; an independent monitor pops and
// compares whenever the DUT completes an output transfer.
// -----------------------------------------------------------------------------
module tb_des_perm_unit;

    localparam int STAGES = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_mode;
    logic [63:0] data_in;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_mode;
    logic [63:0] data_out;
    logic        busy;

    des_perm_unit #(
        .STAGES (STAGES),
        .W      (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mode  (out_mode),
        .data_out  (data_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  mode;
        logic [63:0] data;
        int          acc_cyc;
        bit          chk_lat;
    } exp_t;

    exp_t exp_q [$];
    exp_t mon_e;

    // FIPS P table, 1-based; the other permutations are derived from rules.
    int p_t [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                     2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%016h, expected 0x%016h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int bit_of(input logic [63:0] x, input int pos);
        return int'((x >> pos) & 64'd1);
    endfunction

    // IP rows start at 58,60,62,64,57,59,61,63 and step down by 8 (1-based).
    function automatic int ip_src(input int i);
        int r;
        int c;
        int start;
        r     = i / 8;
        c     = i % 8;
        start = (r < 4) ? (58 + 2 * r) : (57 + 2 * (r - 4));
        return start - 8 * c - 1;
    endfunction

    function automatic logic [63:0] ref_perm(input logic [1:0] m, input logic [63:0] x);
        logic [63:0] y;
        y = 64'd0;
        case (m)
            2'd0: for (int i = 0; i < 32; i++)
                      y = y | (64'(bit_of(x, p_t[i] - 1)) << i);
            // E: row r of 6 takes FIPS bits 4r..4r+5, wrapping around 32.
            2'd1: for (int i = 0; i < 48; i++)
                      y = y | (64'(bit_of(x, (4 * (i / 6) + (i % 6) + 31) % 32)) << i);
            2'd2: for (int i = 0; i < 64; i++)
                      y = y | (64'(bit_of(x, ip_src(i))) << i);
            // FP is the inverse of IP: scatter instead of gather.
            default: for (int i = 0; i < 64; i++)
                      y = y | (64'(bit_of(x, i)) << ip_src(i));
        endcase
        return y;
    endfunction

    // Monitor: a transfer happens at the next rising edge when valid and
    // ready are both high at the preceding falling edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", {63'd0, out_valid}, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_data", data_out, mon_e.data);
                check("out_mode", {62'd0, out_mode}, {62'd0, mon_e.mode});
                if (mon_e.chk_lat)
                    check("latency", 64'(cyc - mon_e.acc_cyc), 64'(STAGES));
            end
        end
    end

    task automatic send(input logic [1:0] m, input logic [63:0] d, input logic [63:0] exp,
                        input bit lat, output int waited);
        exp_t e;
        in_valid = 1'b1;
        in_mode  = m;
        data_in  = d;
        waited   = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready) begin
                e.mode    = m;
                e.data    = exp;
                e.acc_cyc = cyc;
                e.chk_lat = lat;
                exp_q.push_back(e);
                break;
            end
            waited++;
            if (waited > 50) begin
                check("send_timeout", {63'd0, in_ready}, 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        int          stalls;
        logic [1:0]  m;
        logic [63:0] x;
        logic [63:0] y;
        logic [63:0] a_exp;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mode   = 2'd0;
        data_in   = 64'd0;
        out_ready = 1'b1;

        // Reset state; an input offered while in reset must be refused.
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b1;
        data_in  = 64'h1234_5678_9abc_def0;
        @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_data_out", data_out, 64'd0);
        check("rst_out_mode", {62'd0, out_mode}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("post_rst_busy", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;

        // Directed vectors with hand-derived expected words.
        send(2'd0, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0100, 1'b1, w);
        send(2'd0, 64'h0000_0000_0000_8000, 64'h0000_0000_0000_0001, 1'b1, w);
        send(2'd0, 64'hffff_ffff_0000_0001, 64'h0000_0000_0000_0100, 1'b1, w);
        send(2'd1, 64'h0000_0000_0000_0001, 64'h0000_8000_0000_0002, 1'b1, w);
        send(2'd1, 64'h0000_0000_ffff_ffff, 64'h0000_ffff_ffff_ffff, 1'b1, w);
        send(2'd2, 64'h0000_0000_0000_0001, 64'h0000_0080_0000_0000, 1'b1, w);
        send(2'd3, 64'h0000_0080_0000_0000, 64'h0000_0000_0000_0001, 1'b1, w);
        wait_drain();

        // Random IP -> FP round trips must restore the original word.
        for (int i = 0; i < 10; i++) begin
            x = {$urandom, $urandom};
            y = ref_perm(2'd2, x);
            send(2'd2, x, y, 1'b1, w);
            send(2'd3, y, x, 1'b1, w);
        end
        wait_drain();

        // 100 back-to-back mixed-mode words, consumer always ready.
        stalls = 0;
        for (int i = 0; i < 100; i++) begin
            m = 2'($urandom_range(0, 3));
            x = {$urandom, $urandom};
            send(m, x, ref_perm(m, x), 1'b1, w);
            stalls += w;
        end
        check("stream_stalls", 64'(stalls), 64'd0);
        wait_drain();

        // Backpressure: two words fill the pipe, the third is refused.
        out_ready = 1'b0;
        x = {$urandom, $urandom};
        a_exp = ref_perm(2'd1, x);
        send(2'd1, x, a_exp, 1'b0, w);
        x = {$urandom, $urandom};
        send(2'd0, x, ref_perm(2'd0, x), 1'b0, w);
        x = {$urandom, $urandom};
        in_valid = 1'b1;
        in_mode  = 2'd2;
        data_in  = x;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", {63'd0, in_ready}, 64'd0);
            check("bp_out_valid", {63'd0, out_valid}, 64'd1);
            check("bp_hold_data", data_out, a_exp);
            check("bp_hold_mode", {62'd0, out_mode}, 64'd1);
            @(posedge clk);
            #1;
        end
        check("bp_accepted", 64'(exp_q.size()), 64'd2);
        out_ready = 1'b1;
        send(2'd2, x, ref_perm(2'd2, x), 1'b0, w);
        wait_drain();

        // Reset with two words in flight: everything discarded.
        x = {$urandom, $urandom};
        send(2'd3, x, ref_perm(2'd3, x), 1'b1, w);
        x = {$urandom, $urandom};
        send(2'd0, x, ref_perm(2'd0, x), 1'b1, w);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_mode  = 2'd1;
        data_in  = {$urandom, $urandom};
        @(negedge clk);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        check("midrst_data_out", data_out, 64'd0);
        repeat (6) @(posedge clk);
        #1;
        check("midrst_still_idle", {63'd0, busy}, 64'd0);

        // Pipe still works after the reset.
        send(2'd0, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0100, 1'b1, w);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/des_perm_unit.md
DES_PERM_UNIT -- requirements
Module: des_perm_unit

Interface
REQ-001 The module SHALL have parameter STAGES, default 2, giving the number of pipeline register stages (legal 1..4).
REQ-002 The module SHALL have parameter W, default 64, giving the data port width (fixed at 64; all modes are zero-padded into it).
REQ-003 The module SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The module SHALL have port in_valid  input  1  the input word is valid.
REQ-006 The module SHALL have port in_ready  output  1  the unit accepts the input this cycle.
REQ-007 The module SHALL have port in_mode  input  2  the permutation select: 0=P (32->32), 1=E (32->48), 2=IP (64->64), 3=FP (64->64).
REQ-008 The module SHALL have port data_in  input  W  the input word; bits above the mode's input width are ignored.
REQ-009 The module SHALL have port out_valid  output  1  the result is valid.
REQ-010 The module SHALL have port out_ready  input  1  the consumer accepts the result.
REQ-011 The module SHALL have port out_mode  output  2  the mode that travelled with the result.
REQ-012 The module SHALL have port data_out  output  W  the permuted word; bits above the mode's output width are 0.
REQ-013 The module SHALL have port busy  output  1  at least one stage holds valid data.

Function
REQ-014 Bit numbering SHALL be: port bit i equals FIPS 46-3 bit i+1, so out[i] = in[T[i]-1] for table T (e.g. P: out[0]=in[15], out[8]=in[0]).
REQ-015 The permutation SHALL be applied combinationally on data_in and captured into stage 0 with in_mode.
REQ-016 Each stage s SHALL hold {valid, mode, data} and advance to s+1 when stage s+1 is empty or advancing.
REQ-017 The last stage SHALL drive out_valid/out_mode/data_out directly from registers and SHALL advance when out_ready is high.
REQ-018 Transfer SHALL occur on in_valid&&in_ready and on out_valid&&out_ready; latency SHALL be exactly STAGES cycles with no backpressure.
REQ-019 in_ready SHALL be !stage0.valid || stage0 advancing, so that full throughput of 1 word/cycle is sustained.
REQ-020 While out_valid is high and out_ready is low, data_out and out_mode SHALL be held stable.
REQ-021 With all stages full and out_ready low, in_ready SHALL be 0 and no data SHALL be dropped or duplicated.
REQ-022 Simultaneous input accept and output drain on a full pipe SHALL both complete in the same cycle.
REQ-023 Results SHALL exit in acceptance order; modes MAY differ per word.
REQ-024 busy SHALL be the OR of all stage valid bits.

Reset
REQ-025 On rst, all stage valid bits SHALL clear, giving out_valid=0, busy=0, in_ready=1 on the following cycle.
REQ-026 On rst, data_out and out_mode SHALL be 0.
REQ-027 Reset mid-operation SHALL discard all in-flight words, and no result of a pre-reset word SHALL emerge.
REQ-028 An input presented during the reset cycle SHALL NOT be accepted.

Structure
REQ-029 Tables P[32], E[48], IP[64] and FP[64] (FIPS 1-based), the mode enum and the width constants SHALL live in package des_pkg.
REQ-030 A sub-module des_perm_stage (one register stage with valid/ready) SHALL be instantiated STAGES times via generate.
REQ-031 Table application SHALL be a combinational function in des_pkg; it SHALL contain no state.

Verification
REQ-032 A bench SHALL drive P mode with data_in=0x0000_0000_0000_0001 and require data_out=0x0000_0000_0000_0100 after STAGES cycles.
REQ-033 A bench SHALL drive E mode with data_in=0x0000_0000_0000_0001 and require data_out=0x0000_8000_0000_0002.
REQ-034 A bench SHALL drive IP mode with data_in=0x1 and require data_out=0x0000_0080_0000_0000, then feed that result in FP mode and require 0x1 (also random IP->FP round trips).
REQ-035 A bench SHALL run STAGES=2 with out_ready=0, offer 3 words, and require 2 accepted and in_ready=0 on the 3rd; on release with out_ready=1, it SHALL require all 3 out in order and unchanged.
REQ-036 A bench SHALL stream 100 back-to-back mixed-mode words with out_ready=1 and require one result per cycle, matching a reference model.
REQ-037 A bench SHALL assert rst with 2 words in flight and require out_valid=0 and busy=0 next cycle, and no stale output afterwards.
